// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 VGA timing constants
// Purpose: timing constants shared by the scan generator and the sprite/text drawers.
// Ports: none (package).
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = 800;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = 525;

    localparam int unsigned CNT_W = 10;

    // Inclusive counter windows, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] H_VIS_LAST   = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST   = CNT_W'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - scan position and sync bundle
// Purpose: groups the scan generator outputs for pixel drawers.
// Signals: DrawX/DrawY position, hs/vs sync, blank display-enable,
//          frame_start pulse, frame_count.
interface vga_scan_gen_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] DrawX;
    logic [CNT_W-1:0] DrawY;
    logic             hs;
    logic             vs;
    logic             blank;
    logic             frame_start;
    logic [7:0]       frame_count;

    modport master (output DrawX, DrawY, hs, vs, blank, frame_start, frame_count);
    modport slave  (input  DrawX, DrawY, hs, vs, blank, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - terminal-count counter with wrap output
// Purpose: one scan axis; counts 0..TOTAL-1 while en_i is high.
// Ports: clk, rst (async active-high), en_i advance enable,
//        cnt_o current count, nxt_o next-state count, wrap_o high when
//        this edge takes the count from TOTAL-1 back to 0.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL = H_TOTAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] nxt_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    always_comb begin
        wrap  = en_i && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign nxt_o  = cnt_d;
    assign wrap_o = wrap;

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - 640x480 VGA scan position and sync generator
// Purpose: pixel/line counters plus registered sync, blank and frame markers.
// Ports: vga_clk pixel clock, Reset async active-high,
//        vga (master) DrawX/DrawY/hs/vs/blank/frame_start/frame_count.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic            vga_clk,
    input  logic            Reset,
    vga_scan_gen_if.master  vga
);

    logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic             h_wrap, v_wrap;

    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       fs_q, fs_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_hcnt (
        .clk    (vga_clk),
        .rst    (Reset),
        .en_i   (1'b1),
        .cnt_o  (h_cnt),
        .nxt_o  (h_nxt),
        .wrap_o (h_wrap)
    );

    // Lines only advance on the pixel wrap, so the vertical wrap already
    // implies the (799,524) -> (0,0) frame boundary.
    vga_axis_counter #(.TOTAL(V_TOTAL)) u_vcnt (
        .clk    (vga_clk),
        .rst    (Reset),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .nxt_o  (v_nxt),
        .wrap_o (v_wrap)
    );

    // Decoded from next-state counts so the registered flags land on the
    // same edge as the counters they describe.
    always_comb begin
        hs_d        = in_window(h_nxt, H_SYNC_FIRST, H_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
        vs_d        = in_window(v_nxt, V_SYNC_FIRST, V_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
        blank_d     = (h_nxt <= H_VIS_LAST) && (v_nxt <= V_VIS_LAST);
        fs_d        = v_wrap;
        frame_cnt_d = frame_cnt_q + {7'd0, fs_d};
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            blank_q     <= 1'b1;
            fs_q        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            fs_q        <= fs_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign vga.DrawX       = h_cnt;
    assign vga.DrawY       = v_cnt;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.blank       = blank_q;
    assign vga.frame_start = fs_q;
    assign vga.frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen
module tb_vga_scan_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #20 clk = ~clk;

    vga_scan_gen_if vga0 ();
    vga_scan_gen_if vga1 ();

    vga_scan_gen #(.SYNC_POL(1'b0)) dut0 (.vga_clk(clk), .Reset(rst), .vga(vga0));
    vga_scan_gen #(.SYNC_POL(1'b1)) dut1 (.vga_clk(clk), .Reset(rst), .vga(vga1));

    int tests = 0;
    int fails = 0;

    int   m_x, m_y, m_fc;
    logic m_fs;

    logic [63:0] sb_q[$];

    int hs0_low, hs1_high, first_hs, blank_cnt, vs0_low, vs1_high, fs_pulses;

    function automatic logic [31:0] expect_vec(input logic pol, input int x, input int y,
                                               input logic fs, input int fc);
        logic hs, vs, bl;
        logic [9:0] xv, yv;
        logic [7:0] fcv;
        hs  = (x >= 656 && x <= 751) ? pol : ~pol;
        vs  = (y >= 490 && y <= 491) ? pol : ~pol;
        bl  = (x < 640) && (y < 480);
        xv  = 10'(x);
        yv  = 10'(y);
        fcv = 8'(fc);
        return {xv, yv, hs, vs, bl, fs, fcv};
    endfunction

    function automatic logic [31:0] obs0();
        return {vga0.DrawX, vga0.DrawY, vga0.hs, vga0.vs, vga0.blank,
                vga0.frame_start, vga0.frame_count};
    endfunction

    function automatic logic [31:0] obs1();
        return {vga1.DrawX, vga1.DrawY, vga1.hs, vga1.vs, vga1.blank,
                vga1.frame_start, vga1.frame_count};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_fc = 0; m_fs = 1'b0;
    endtask

    task automatic model_advance();
        m_fs = 1'b0;
        if (m_x == 799) begin
            m_x = 0;
            if (m_y == 524) begin
                m_y  = 0;
                m_fs = 1'b1;
                m_fc = (m_fc + 1) % 256;
            end else begin
                m_y++;
            end
        end else begin
            m_x++;
        end
    endtask

    task automatic push_expect();
        sb_q.push_back({expect_vec(1'b1, m_x, m_y, m_fs, m_fc),
                        expect_vec(1'b0, m_x, m_y, m_fs, m_fc)});
    endtask

    task automatic compare_pop(input string tag);
        logic [63:0] e;
        e = sb_q.pop_front();
        check({tag, "_pol0"}, obs0(), e[31:0]);
        check({tag, "_pol1"}, obs1(), e[63:32]);
    endtask

    // One pixel clock: expectation queued at the edge, compared half a cycle later.
    task automatic step(input string tag);
        @(posedge clk);
        model_advance();
        push_expect();
        @(negedge clk);
        compare_pop(tag);
    endtask

    // Relocate the scan position of both DUTs between edges.
    task automatic jump(input int x, input int y);
        force dut0.u_hcnt.cnt_q = 10'(x);
        force dut0.u_vcnt.cnt_q = 10'(y);
        force dut1.u_hcnt.cnt_q = 10'(x);
        force dut1.u_vcnt.cnt_q = 10'(y);
        #1;
        release dut0.u_hcnt.cnt_q;
        release dut0.u_vcnt.cnt_q;
        release dut1.u_hcnt.cnt_q;
        release dut1.u_vcnt.cnt_q;
        m_x = x;
        m_y = y;
    endtask

    task automatic preload_fc(input int fc);
        force dut0.frame_cnt_q = 8'(fc);
        force dut1.frame_cnt_q = 8'(fc);
        #1;
        release dut0.frame_cnt_q;
        release dut1.frame_cnt_q;
        m_fc = fc;
    endtask

    initial begin
        // Reset state
        model_reset();
        @(negedge clk);
        push_expect();
        compare_pop("reset");
        @(negedge clk);
        push_expect();
        compare_pop("reset_hold");

        // First line after release
        rst = 1'b0;
        hs0_low = 0; hs1_high = 0; first_hs = -1; blank_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            step("line");
            if (vga0.hs === 1'b0) begin
                hs0_low++;
                if (first_hs < 0) first_hs = int'(vga0.DrawX);
            end
            if (vga1.hs === 1'b1) hs1_high++;
            if (vga0.blank === 1'b1) blank_cnt++;
        end
        check("line_wrap_xy", {12'd0, vga0.DrawX, vga0.DrawY}, {12'd0, 10'd0, 10'd1});
        check("hs_low_count", 32'(hs0_low), 32'd96);
        check("hs_first_x", 32'(first_hs), 32'd656);
        check("hs_pol1_high_count", 32'(hs1_high), 32'd96);
        check("blank_line_count", 32'(blank_cnt), 32'd640);

        // Vertical sync window: lines 489..492
        jump(799, 488);
        vs0_low = 0; vs1_high = 0;
        for (int i = 0; i < 3200; i++) begin
            step("vwin");
            if (vga0.vs === 1'b0) vs0_low++;
            if (vga1.vs === 1'b1) vs1_high++;
        end
        check("vs_low_count", 32'(vs0_low), 32'd1600);
        check("vs_pol1_high_count", 32'(vs1_high), 32'd1600);

        // Visible-area corners
        jump(637, 479);
        step("corner");
        step("corner");
        check("blank_639_479", {31'd0, vga0.blank}, 32'd1);
        step("corner");
        check("blank_640_479", {31'd0, vga0.blank}, 32'd0);
        jump(638, 480);
        step("corner");
        check("blank_639_480", {31'd0, vga0.blank}, 32'd0);

        // Frame boundary
        jump(795, 524);
        for (int i = 0; i < 4; i++) step("frame_end");
        step("frame_wrap");
        check("fs_at_wrap", {31'd0, vga0.frame_start}, 32'd1);
        check("fc_after_frame", {24'd0, vga0.frame_count}, 32'd1);
        check("blank_at_origin", {31'd0, vga0.blank}, 32'd1);
        step("after_wrap");
        check("fs_single_cycle", {31'd0, vga0.frame_start}, 32'd0);

        // frame_count wrap 255 -> 0
        preload_fc(254);
        fs_pulses = 0;
        for (int f = 0; f < 2; f++) begin
            jump(798, 524);
            for (int i = 0; i < 3; i++) begin
                step("fc_wrap");
                if (vga0.frame_start === 1'b1) fs_pulses++;
            end
        end
        check("fc_wrapped", {24'd0, vga0.frame_count}, 32'd0);
        check("fc_wrap_pulses", 32'(fs_pulses), 32'd2);

        // Asynchronous reset mid-frame
        jump(699, 300);
        step("pre_reset");
        check("pre_reset_xy", {12'd0, vga0.DrawX, vga0.DrawY}, {12'd0, 10'd700, 10'd300});
        rst = 1'b1;
        #1;
        model_reset();
        push_expect();
        compare_pop("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_expect();
            compare_pop("reset_mid");
        end
        rst = 1'b0;
        step("restart");
        check("restart_x1", {22'd0, vga0.DrawX}, 32'd1);
        for (int i = 0; i < 10; i++) step("restart_run");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter SYNC_POL, default 0, sync active level: 0 = hs/vs low during sync pulse, 1 = high.
REQ-002 vga_clk  input  1  pixel clock, 25 MHz nominal; all state on posedge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 DrawX  output  10  current horizontal pixel counter, 0..799.
REQ-005 DrawY  output  10  current vertical line counter, 0..524.
REQ-006 hs  output  1  horizontal sync.
REQ-007 vs  output  1  vertical sync.
REQ-008 blank  output  1  display-enable: 1 inside the visible 640x480 area, 0 in porches/sync (pixel drawers gate colour with it).
REQ-009 frame_start  output  1  one-cycle pulse marking the first pixel of a new frame.
REQ-010 frame_count  output  8  frames completed since reset, wraps.

Function
REQ-011 Horizontal timing SHALL be: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799 (800 total).
REQ-012 Vertical timing SHALL be: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524 (525 total).
REQ-013 DrawX SHALL increment by 1 every vga_clk and wrap 799 -> 0.
REQ-014 DrawY SHALL increment by 1 only on the cycle DrawX wraps 799 -> 0, and wrap 524 -> 0 on that same cycle when DrawY = 524.
REQ-015 hs, vs, blank, frame_start SHALL be registered and cycle-aligned with DrawX/DrawY: each reflects the counter values present on the same cycle (computed from next-state counter values, zero added latency).
REQ-016 hs SHALL equal SYNC_POL when DrawX is 656..751, else ~SYNC_POL.
REQ-017 vs SHALL equal SYNC_POL when DrawY is 490..491 (for the full lines, all 800 pixels), else ~SYNC_POL.
REQ-018 blank SHALL be 1 iff DrawX <= 639 and DrawY <= 479.
REQ-019 frame_start SHALL be 1 only on the cycle where (DrawX, DrawY) becomes (0,0) via wrap from (799,524); it SHALL NOT assert on the first cycle after reset release.
REQ-020 frame_count SHALL increment by 1 (mod 256) on the same edge frame_start is asserted; 255 -> 0 wraps silently.
REQ-021 Counter comparisons SHALL use 10-bit unsigned arithmetic; counter values above the terminal count are unreachable and need no handling.

Reset
REQ-022 While Reset is high: DrawX = 0, DrawY = 0, hs = ~SYNC_POL, vs = ~SYNC_POL, blank = 1, frame_start = 0, frame_count = 0.
REQ-023 Reset asserted mid-frame SHALL force the reset values immediately (asynchronously); no partial line or frame completes.
REQ-024 First rising edge after Reset deasserts SHALL advance DrawX to 1; the first frame runs full-length from (0,0).

Structure
REQ-025 Timing constants (H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525) SHALL live in shared package vga_pkg, reused by sprite/text drawers.
REQ-026 Block SHALL be flat; optional single sub-module vga_axis_counter (terminal-count counter with wrap output) instantiated once per axis.

Verification
REQ-027 Release Reset, run 800 clocks -> DrawX sequence 0..799 then 0, DrawY 0 -> 1 exactly at the wrap, hs low for exactly 96 clocks starting DrawX=656.
REQ-028 Run one full frame (420000 clocks) -> vs low for exactly 1600 clocks spanning DrawY 490-491; blank high for exactly 307200 clocks; frame_start one pulse at clock 420000, frame_count = 1.
REQ-029 Sample (639,479)/(640,479)/(639,480) -> blank = 1/0/0; (0,0) after first wrap -> blank = 1, frame_start = 1.
REQ-030 Assert Reset at DrawX=700, DrawY=300 -> all outputs at reset values within the same cycle, no frame_start; after release, counting restarts from (0,0).
REQ-031 Run 256 frames -> frame_count returns to 0 on the 256th frame_start, 256 pulses total.
REQ-032 SYNC_POL=1 build, one line -> hs high for DrawX 656..751, low elsewhere; vs high only on DrawY 490-491.
